// File: rtl/fpga_carry_pkg.sv
// Shared types for the multi-beat carry chain: arithmetic mode and chain FSM state.
package fpga_carry_pkg;

   typedef enum logic {
      CARRY_ADD = 1'b0,
      CARRY_SUB = 1'b1
   } carry_mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      CHAIN = 1'b1
   } chain_state_e;

endpackage

// File: rtl/fpga_carry_logic.sv
// One-bit full-adder cell: majority carry and xor sum.
module fpga_carry_logic (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fpga_carry_chain.sv
// Multi-beat ripple adder/subtractor: one WIDTH-bit word per beat, carry and
// zero flag carried across beats, all results registered with one cycle latency.
module fpga_carry_chain
   import fpga_carry_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             fcin_i,
   input  logic             mode_i,
   input  logic             first_i,
   input  logic             last_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             fcout_o,
   output logic             overflow_o,
   output logic             zero_o,
   output logic             valid_o
);

   chain_state_e     state_q;
   chain_state_e     state_d;
   carry_mode_e      mode_q;
   carry_mode_e      mode_eff;
   logic             carry_q;
   logic             is_first;
   logic             cin;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] s;
   logic [WIDTH:0]   c;

   // Any beat seen in IDLE, or an explicit first_i, starts a fresh operation.
   always_comb begin
      state_d  = state_q;
      is_first = (state_q == IDLE) || first_i;
      mode_eff = is_first ? carry_mode_e'(mode_i) : mode_q;
      cin      = carry_q;
      b_eff    = b_i;
      if (is_first) begin
         cin = (mode_eff == CARRY_SUB) ? 1'b1 : fcin_i;
      end
      if (mode_eff == CARRY_SUB) begin
         b_eff = ~b_i;
      end
      if (valid_i) begin
         state_d = last_i ? IDLE : CHAIN;
      end
   end

   assign c[0] = cin;

   for (genvar k = 0; k < WIDTH; k++) begin : g_bit
      fpga_carry_logic u_cell (
         .a    (a_i[k]),
         .b    (b_eff[k]),
         .cin  (c[k]),
         .sum  (s[k]),
         .cout (c[k+1])
      );
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Result, flag and cross-beat registers; all hold while no beat is offered.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         sum_o      <= '0;
         fcout_o    <= 1'b0;
         overflow_o <= 1'b0;
         zero_o     <= 1'b0;
         valid_o    <= 1'b0;
         carry_q    <= 1'b0;
         mode_q     <= CARRY_ADD;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            sum_o      <= s;
            fcout_o    <= c[WIDTH];
            overflow_o <= last_i & (c[WIDTH] ^ c[WIDTH-1]);
            zero_o     <= (s == '0) & (is_first | zero_o);
            carry_q    <= c[WIDTH];
            mode_q     <= mode_eff;
         end
      end
   end

endmodule

// File: tb/tb_fpga_carry_chain.sv
// Directed bench for fpga_carry_chain at WIDTH = 8 with hand-computed expectations.
module tb_fpga_carry_chain;

   logic       clk_i = 1'b0;
   logic       reset_ni = 1'b0;
   logic       valid_i = 1'b0;
   logic [7:0] a_i = '0;
   logic [7:0] b_i = '0;
   logic       fcin_i = 1'b0;
   logic       mode_i = 1'b0;
   logic       first_i = 1'b0;
   logic       last_i = 1'b0;
   logic [7:0] sum_o;
   logic       fcout_o;
   logic       overflow_o;
   logic       zero_o;
   logic       valid_o;

   int checks = 0;
   int errors = 0;

   fpga_carry_chain #(.WIDTH(8)) dut (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .valid_i    (valid_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .fcin_i     (fcin_i),
      .mode_i     (mode_i),
      .first_i    (first_i),
      .last_i     (last_i),
      .sum_o      (sum_o),
      .fcout_o    (fcout_o),
      .overflow_o (overflow_o),
      .zero_o     (zero_o),
      .valid_o    (valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] sum, input logic fc,
                            input logic ovf, input logic zero, input logic vld);
      check({tag, ".sum"},      64'(sum_o),      64'(sum));
      check({tag, ".fcout"},    64'(fcout_o),    64'(fc));
      check({tag, ".overflow"}, 64'(overflow_o), 64'(ovf));
      check({tag, ".zero"},     64'(zero_o),     64'(zero));
      check({tag, ".valid"},    64'(valid_o),    64'(vld));
   endtask

   task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic fcin,
                       input logic mode, input logic first, input logic last);
      valid_i = 1'b1;
      a_i     = a;
      b_i     = b;
      fcin_i  = fcin;
      mode_i  = mode;
      first_i = first;
      last_i  = last;
      @(posedge clk_i);
      #1;
   endtask

   // Idle cycle with junk on the data inputs to show it is ignored.
   task automatic gap();
      valid_i = 1'b0;
      a_i     = 8'hA5;
      b_i     = 8'h3C;
      fcin_i  = 1'b1;
      mode_i  = 1'b1;
      first_i = 1'b1;
      last_i  = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [8:0] wide;
      logic       ta, tb, tc, maj;

      // Reset state
      reset_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_ni = 1'b1;

      // Single-beat ADD 0x01 + 0xFF
      beat(8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
      check_all("add_01_ff", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      gap();
      check_all("idle_hold", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

      // Single-beat SUB 0x05 - 0x07
      beat(8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1);
      check_all("sub_05_07", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);

      // Signed overflow 0x7F + 0x01
      beat(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
      check_all("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

      // Two-beat ADD 0x01FF + 0x0001
      beat(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
      check_all("chain_b1", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      beat(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      check_all("chain_b2", 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

      // Same chain with a 3-cycle gap; mode_i=1 on beat 2 must be ignored
      beat(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
      check_all("gap_b1", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         gap();
         check_all("gap_idle", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      beat(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      check_all("gap_b2", 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

      // Restart in CHAIN: stored carry discarded
      beat(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
      beat(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
      check_all("restart", 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset mid-chain: next beat is a first beat with c0 = fcin_i
      beat(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
      valid_i  = 1'b0;
      reset_ni = 1'b0;
      @(posedge clk_i);
      #1;
      check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_ni = 1'b1;
      beat(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      check_all("post_reset", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);

      // Truth table of (a, b, c0) in ADD; replicated bits make fcout the bit function
      for (int i = 0; i < 8; i++) begin
         ta   = i[2];
         tb   = i[1];
         tc   = i[0];
         maj  = (ta & tb) | (ta & tc) | (tb & tc);
         wide = {1'b0, {8{ta}}} + {1'b0, {8{tb}}} + 9'(tc);
         beat({8{ta}}, {8{tb}}, tc, 1'b0, 1'b1, 1'b1);
         check("tt.fcout", 64'(fcout_o), 64'(maj));
         check("tt.sum",   64'(sum_o),   64'(wide[7:0]));
      end

      valid_i = 1'b0;
      @(posedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
